// File: rtl/wormhole_port_allocator_pkg.sv
// Shared constants and types for the per-output-port wormhole allocator.
package wormhole_port_allocator_pkg;

    localparam int unsigned NPORTS = 5;
    localparam int unsigned LEN_W  = 12;
    localparam int unsigned FT_W   = 3;
    localparam int unsigned IDX_W  = $clog2(NPORTS);
    localparam int unsigned SUM_W  = IDX_W + 1;

    // Any code other than header or tail behaves as a body flit.
    localparam logic [FT_W-1:0] FT_HEADER = 3'b001;
    localparam logic [FT_W-1:0] FT_TAIL   = 3'b100;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } alloc_state_t;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NPORTS - 1)) ? '0 : i + IDX_W'(1);
    endfunction

endpackage

// File: rtl/wormhole_port_allocator_rr_pick.sv
// Combinational round-robin priority encoder: first set candidate at or after ptr, with wrap.
module wormhole_port_allocator_rr_pick
    import wormhole_port_allocator_pkg::*;
(
    input  logic [NPORTS-1:0] cand,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  idx,
    output logic              found
);

    logic [NPORTS-1:0] rot;
    logic [SUM_W-1:0]  sum;

    // Rotate so that ptr lands on bit 0, then take the lowest set bit.
    always_comb begin
        rot   = NPORTS'({cand, cand} >> ptr);
        found = 1'b0;
        sum   = '0;
        for (int j = 0; j < NPORTS; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + SUM_W'(j);
            end
        end
        if (sum >= SUM_W'(NPORTS)) begin
            sum = sum - SUM_W'(NPORTS);
        end
        idx = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/wormhole_port_allocator.sv
// Per-output-port wormhole allocator: locks one input per packet, counts flits, rotates priority on release.
module wormhole_port_allocator
    import wormhole_port_allocator_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORTS-1:0]        req,
    input  logic [NPORTS*FT_W-1:0]   flit_type,
    input  logic [NPORTS*LEN_W-1:0]  length,
    input  logic                     dcts,
    output logic [NPORTS-1:0]        grant,
    output logic [NPORTS:0]          nextstate,
    output logic                     busy,
    output logic                     pkt_done
);

    alloc_state_t      state;
    logic [IDX_W-1:0]  owner;
    logic [IDX_W-1:0]  rr_ptr;
    logic [LEN_W-1:0]  remain;

    logic [NPORTS-1:0] cand;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_found;
    logic [LEN_W-1:0]  pick_len;
    logic [FT_W-1:0]   owner_ft;
    logic              owner_req;
    logic              gnt_c;
    logic              last_c;

    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            cand[i] = req[i] && (flit_type[i*FT_W +: FT_W] == FT_HEADER);
        end
    end

    wormhole_port_allocator_rr_pick u_rr_pick (
        .cand  (cand),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Per-input muxes: length of the picked header, request and flit type of the owner.
    always_comb begin
        pick_len  = '0;
        owner_ft  = '0;
        owner_req = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_len = length[i*LEN_W +: LEN_W];
            end
            if (owner == IDX_W'(i)) begin
                owner_ft  = flit_type[i*FT_W +: FT_W];
                owner_req = req[i];
            end
        end
    end

    // Early tail and exhausted length both end the packet on the granted flit.
    assign gnt_c  = (state == ST_LOCK) && owner_req && dcts;
    assign last_c = gnt_c && ((remain == '0) || (owner_ft == FT_TAIL));

    always_comb begin
        grant = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (gnt_c && (owner == IDX_W'(i))) begin
                grant[i] = 1'b1;
            end
        end
    end

    // Bit 0 flags that the allocator is idle next cycle: already idle, or releasing now.
    assign nextstate = {grant, (state == ST_IDLE) || last_c};
    assign busy      = (state == ST_LOCK);
    assign pkt_done  = last_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            owner  <= '0;
            remain <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        owner  <= pick_idx;
                        remain <= pick_len;
                        state  <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (last_c) begin
                        rr_ptr <= next_idx(owner);
                        state  <= ST_IDLE;
                    end else if (gnt_c) begin
                        remain <= remain - LEN_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
